// File: rtl/data_memory_responder.sv
// Word-addressed data memory with a valid/ready request channel and a
// valid/ready response channel. A request is accepted only in IDLE, waits a
// fixed number of cycles, then the storage access happens on the edge that
// enters RESP. The response is held until the initiator takes it.
module data_memory_responder #(
    parameter int          MEMORY_DEPTH = 256,
    parameter int          WAIT_STATES  = 2,
    parameter logic [31:0] BASE_ADDRESS = 32'h1001_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [31:0] address_i,
    input  logic [31:0] write_data_i,
    input  logic [3:0]  byte_en_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] read_data_o,
    output logic        error_o
);

    // Index width into the word array; a depth of 1 still needs one bit.
    localparam int IDX_W = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;

    // Byte span of the memory, kept 33 bits wide so very deep memories do
    // not overflow the range comparison.
    localparam logic [32:0] BYTE_SPAN = 33'(64'(MEMORY_DEPTH) * 64'd4);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  count_q, count_d;
    logic [31:0] addr_q, addr_d;
    logic        write_q, write_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] read_data_q, read_data_d;
    logic        error_q, error_d;

    logic [31:0] mem_q [MEMORY_DEPTH];

    // Transaction view used for the storage access: the live inputs when the
    // access happens straight out of IDLE (zero wait states), the captured
    // request otherwise.
    logic [31:0]      txn_addr;
    logic             txn_write;
    logic [31:0]      txn_wdata;
    logic [3:0]       txn_be;
    logic [31:0]      txn_offset;
    logic             txn_error;
    logic [IDX_W-1:0] txn_idx;
    logic [31:0]      cur_word;
    logic [31:0]      merged_word;
    logic             access_en;
    logic             mem_we;

    // Select the request fields and decode offset, range error and the
    // byte-lane merge of store data into the currently stored word.
    always_comb begin
        txn_addr  = addr_q;
        txn_write = write_q;
        txn_wdata = wdata_q;
        txn_be    = be_q;
        if (state_q == IDLE) begin
            txn_addr  = address_i;
            txn_write = req_write_i;
            txn_wdata = write_data_i;
            txn_be    = byte_en_i;
        end
        txn_offset = txn_addr - BASE_ADDRESS;
        txn_error  = (txn_addr[1:0] != 2'b00) || ({1'b0, txn_offset} >= BYTE_SPAN);
        txn_idx    = txn_offset[IDX_W+1:2];
        cur_word   = mem_q[txn_idx];
        for (int lane = 0; lane < 4; lane++) begin
            merged_word[8*lane +: 8] = txn_be[lane] ? txn_wdata[8*lane +: 8]
                                                    : cur_word[8*lane +: 8];
        end
    end

    // Next-state logic: accept in IDLE, count down in WAIT, and perform the
    // access on the transition into RESP; RESP holds until handshake.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        addr_d      = addr_q;
        write_d     = write_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        read_data_d = read_data_q;
        error_d     = error_q;
        access_en   = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    addr_d  = address_i;
                    write_d = req_write_i;
                    wdata_d = write_data_i;
                    be_d    = byte_en_i;
                    if (WAIT_STATES == 0) begin
                        state_d   = RESP;
                        access_en = 1'b1;
                    end else begin
                        state_d = WAIT;
                        count_d = WAIT_INIT;
                    end
                end
            end
            WAIT: begin
                count_d = count_q - 4'd1;
                if (count_q <= 4'd1) begin
                    state_d   = RESP;
                    access_en = 1'b1;
                end
            end
            RESP: begin
                if (resp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = 4'd0;
            end
        endcase

        if (access_en) begin
            error_d     = txn_error;
            read_data_d = (txn_write || txn_error) ? 32'd0 : cur_word;
        end

        mem_we = access_en && txn_write && !txn_error;
    end

    // Control and response registers; reset abandons any transaction in
    // flight but leaves the storage untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            count_q     <= 4'd0;
            addr_q      <= 32'd0;
            write_q     <= 1'b0;
            wdata_q     <= 32'd0;
            be_q        <= 4'd0;
            read_data_q <= 32'd0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            addr_q      <= addr_d;
            write_q     <= write_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            read_data_q <= read_data_d;
            error_q     <= error_d;
        end
    end

    // Storage write; a reset on the RESP-entry edge suppresses the store.
    always_ff @(posedge clk) begin
        if (!reset && mem_we) begin
            mem_q[txn_idx] <= merged_word;
        end
    end

    assign req_ready_o  = (state_q == IDLE);
    assign resp_valid_o = (state_q == RESP);
    assign read_data_o  = read_data_q;
    assign error_o      = error_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Self-checking bench for data_memory_responder: a default-parameter instance
// driven from a vector table plus hand-written corner sequences, and a
// zero-wait-state instance for back-to-back handshakes.
module tb_data_memory_responder;

    localparam int WS = 2;

    logic        clk = 1'b0;
    logic        reset;

    logic        req_valid, req_ready, req_write, resp_valid, resp_ready, error;
    logic [31:0] address, write_data, read_data;
    logic [3:0]  byte_en;

    logic        req_valid_z, req_ready_z, req_write_z, resp_valid_z, resp_ready_z, error_z;
    logic [31:0] address_z, write_data_z, read_data_z;
    logic [3:0]  byte_en_z;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_data;
        logic        exp_err;
        string       name;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } resp_t;

    resp_t sb_q[$];
    resp_t zq[$];
    vec_t  vecs[16];

    data_memory_responder #(
        .MEMORY_DEPTH(256),
        .WAIT_STATES (WS),
        .BASE_ADDRESS(32'h1001_0000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_write_i (req_write),
        .address_i   (address),
        .write_data_i(write_data),
        .byte_en_i   (byte_en),
        .resp_valid_o(resp_valid),
        .resp_ready_i(resp_ready),
        .read_data_o (read_data),
        .error_o     (error)
    );

    data_memory_responder #(
        .MEMORY_DEPTH(256),
        .WAIT_STATES (0),
        .BASE_ADDRESS(32'h1001_0000)
    ) dut_z (
        .clk         (clk),
        .reset       (reset),
        .req_valid_i (req_valid_z),
        .req_ready_o (req_ready_z),
        .req_write_i (req_write_z),
        .address_i   (address_z),
        .write_data_i(write_data_z),
        .byte_en_i   (byte_en_z),
        .resp_valid_o(resp_valid_z),
        .resp_ready_i(resp_ready_z),
        .read_data_o (read_data_z),
        .error_o     (error_z)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Hard stop in case a sequence wedges.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic vec_t mkVec(input logic wr, input logic [31:0] a, input logic [31:0] d,
                                   input logic [3:0] be, input logic [31:0] ed, input logic ee,
                                   input string nm);
        vec_t v;
        v.write = wr; v.addr = a; v.wdata = d; v.be = be;
        v.exp_data = ed; v.exp_err = ee; v.name = nm;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Called at posedge+1 with the DUT in IDLE; returns at accept edge + 1.
    task automatic startRequest(input string name, input logic wr, input logic [31:0] a,
                                input logic [31:0] d, input logic [3:0] be);
        req_write  = wr;
        address    = a;
        write_data = d;
        byte_en    = be;
        req_valid  = 1'b1;
        checkOutput({name, "_ready_before_accept"}, 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic waitResponse(input string name, output int lat);
        lat = 1;
        while (!resp_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!resp_valid) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout: no response after %0d cycles, expected one", name, lat);
        end
    endtask

    task automatic finishResponse(input string name);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        checkOutput({name, "_ready_after_hs"}, 32'(req_ready), 32'd1);
        checkOutput({name, "_valid_after_hs"}, 32'(resp_valid), 32'd0);
    endtask

    // One full transaction on the default instance with scoreboard compare.
    task automatic applyStimulus(input vec_t v);
        int    lat;
        resp_t exp;
        exp.data = v.exp_data;
        exp.err  = v.exp_err;
        sb_q.push_back(exp);
        startRequest(v.name, v.write, v.addr, v.wdata, v.be);
        waitResponse(v.name, lat);
        checkOutput({v.name, "_latency"}, 32'(lat), 32'(WS + 1));
        exp = sb_q.pop_front();
        if (resp_valid) begin
            checkOutput({v.name, "_data"}, read_data, exp.data);
            checkOutput({v.name, "_err"}, 32'(error), 32'(exp.err));
        end
        finishResponse(v.name);
    endtask

    // Main sequence: reset, vector table, then multi-cycle corner cases.
    initial begin
        int    lat;
        int    accepts;
        logic  exp_acc;
        resp_t r;
        vec_t  v;

        reset = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; address = '0; write_data = '0; byte_en = '0; resp_ready = 1'b0;
        req_valid_z = 1'b0; req_write_z = 1'b0; address_z = '0; write_data_z = '0; byte_en_z = '0;
        resp_ready_z = 1'b0;

        vecs[0]  = mkVec(1'b1, 32'h1001_0004, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, "st_deadbeef");
        vecs[1]  = mkVec(1'b0, 32'h1001_0004, 32'h0,         4'hF, 32'hDEAD_BEEF, 1'b0, "ld_deadbeef");
        vecs[2]  = mkVec(1'b1, 32'h1001_0000, 32'h1122_3344, 4'hF, 32'h0, 1'b0, "st_word0");
        vecs[3]  = mkVec(1'b1, 32'h1001_0000, 32'hAABB_CCDD, 4'h5, 32'h0, 1'b0, "st_lanes0101");
        vecs[4]  = mkVec(1'b0, 32'h1001_0000, 32'h0,         4'hF, 32'h11BB_33DD, 1'b0, "ld_merged");
        vecs[5]  = mkVec(1'b0, 32'h1001_0002, 32'h0,         4'hF, 32'h0, 1'b1, "ld_misaligned");
        vecs[6]  = mkVec(1'b0, 32'h1001_0400, 32'h0,         4'hF, 32'h0, 1'b1, "ld_past_end");
        vecs[7]  = mkVec(1'b1, 32'h1001_03FC, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0, "st_last_word");
        vecs[8]  = mkVec(1'b1, 32'h1000_FFFC, 32'h5555_5555, 4'hF, 32'h0, 1'b1, "st_below_base");
        vecs[9]  = mkVec(1'b0, 32'h1001_03FC, 32'h0,         4'hF, 32'hCAFE_F00D, 1'b0, "ld_last_word");
        vecs[10] = mkVec(1'b1, 32'h1001_0004, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0, "st_no_lanes");
        vecs[11] = mkVec(1'b0, 32'h1001_0004, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0, "ld_be_ignored");
        vecs[12] = mkVec(1'b1, 32'h1001_0005, 32'h9999_9999, 4'hF, 32'h0, 1'b1, "st_misaligned");
        vecs[13] = mkVec(1'b0, 32'h1001_0004, 32'h0,         4'hF, 32'hDEAD_BEEF, 1'b0, "ld_after_bad_st");
        vecs[14] = mkVec(1'b1, 32'h1001_0400, 32'h7777_7777, 4'hF, 32'h0, 1'b1, "st_past_end");
        vecs[15] = mkVec(1'b0, 32'h1001_0000, 32'h0,         4'hF, 32'h11BB_33DD, 1'b0, "ld_word0_intact");

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_req_ready", 32'(req_ready), 32'd1);
        checkOutput("reset_resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("reset_read_data", read_data, 32'd0);
        checkOutput("reset_error", 32'(error), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i]);
        end

        // Response held for five cycles while a new request is offered.
        r.data = 32'hDEAD_BEEF;
        r.err  = 1'b0;
        sb_q.push_back(r);
        startRequest("hold", 1'b0, 32'h1001_0004, 32'h0, 4'hF);
        waitResponse("hold", lat);
        r = sb_q.pop_front();
        req_valid = 1'b1;
        req_write = 1'b1;
        address   = 32'h1001_0000;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checkOutput($sformatf("hold_valid_%0d", i), 32'(resp_valid), 32'd1);
            checkOutput($sformatf("hold_ready_%0d", i), 32'(req_ready), 32'd0);
            checkOutput($sformatf("hold_data_%0d", i), read_data, r.data);
            checkOutput($sformatf("hold_err_%0d", i), 32'(error), 32'(r.err));
        end
        req_valid = 1'b0;
        finishResponse("hold");
        repeat (2) @(posedge clk);
        #1;
        checkOutput("hold_no_extra_resp", 32'(resp_valid), 32'd0);
        applyStimulus(mkVec(1'b0, 32'h1001_0000, 32'h0, 4'hF, 32'h11BB_33DD, 1'b0, "hold_not_stored"));

        // Reset during the WAIT of a store abandons it.
        applyStimulus(mkVec(1'b1, 32'h1001_0008, 32'h0BAD_F00D, 4'hF, 32'h0, 1'b0, "pre_word2"));
        applyStimulus(mkVec(1'b0, 32'h1001_0004, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b0, "pre_load"));
        startRequest("rst_wait", 1'b1, 32'h1001_0008, 32'h1234_5678, 4'hF);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checkOutput("rst_wait_ready", 32'(req_ready), 32'd1);
        checkOutput("rst_wait_valid", 32'(resp_valid), 32'd0);
        checkOutput("rst_wait_data", read_data, 32'd0);
        checkOutput("rst_wait_err", 32'(error), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checkOutput($sformatf("rst_wait_quiet_%0d", i), 32'(resp_valid), 32'd0);
        end
        applyStimulus(mkVec(1'b0, 32'h1001_0008, 32'h0, 4'hF, 32'h0BAD_F00D, 1'b0, "rst_wait_prior"));

        // Reset while a response is pending drops it.
        startRequest("rst_resp", 1'b0, 32'h1001_0000, 32'h0, 4'hF);
        waitResponse("rst_resp", lat);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checkOutput("rst_resp_ready", 32'(req_ready), 32'd1);
        checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("rst_resp_data", read_data, 32'd0);
        @(posedge clk); #1;
        checkOutput("rst_resp_quiet", 32'(resp_valid), 32'd0);
        applyStimulus(mkVec(1'b0, 32'h1001_03FC, 32'h0, 4'hF, 32'hCAFE_F00D, 1'b0, "rst_mem_kept"));

        // Zero wait states with request and response handshakes held high.
        req_write_z  = 1'b1;
        address_z    = 32'h1001_0010;
        write_data_z = 32'h600D_CAFE;
        byte_en_z    = 4'hF;
        req_valid_z  = 1'b1;
        resp_ready_z = 1'b1;
        accepts = 0;
        for (int i = 0; i < 8; i++) begin
            exp_acc = (i % 2 == 0);
            checkOutput($sformatf("z_ready_%0d", i), 32'(req_ready_z), 32'(exp_acc));
            if (exp_acc) begin
                accepts++;
                r.data = (accepts == 1) ? 32'h0 : 32'h600D_CAFE;
                r.err  = 1'b0;
                zq.push_back(r);
            end
            @(posedge clk); #1;
            req_write_z = 1'b0;
            checkOutput($sformatf("z_valid_%0d", i), 32'(resp_valid_z), 32'(exp_acc));
            if (resp_valid_z && zq.size() > 0) begin
                r = zq.pop_front();
                checkOutput($sformatf("z_data_%0d", i), read_data_z, r.data);
                checkOutput($sformatf("z_err_%0d", i), 32'(error_z), 32'(r.err));
            end
        end
        req_valid_z  = 1'b0;
        resp_ready_z = 1'b0;
        checkOutput("z_queue_drained", 32'(zq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/data_memory_responder.md
DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

Interface
REQ-001 The block SHALL have parameter MEMORY_DEPTH, default 256, meaning the number of 32-bit words of storage.
REQ-002 The block SHALL have parameter WAIT_STATES, default 2, meaning extra cycles between request accept and response (legal range 0..15).
REQ-003 The block SHALL have parameter BASE_ADDRESS, default 32'h1001_0000, meaning the byte address of word 0.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset, with ports as listed below:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous reset, active-high.
- req_valid_i  input  1  initiator presents a request.
- req_ready_o  output  1  responder accepts a request this cycle.
- req_write_i  input  1  1 = store, 0 = load.
- address_i  input  32  byte address.
- write_data_i  input  32  store data.
- byte_en_i  input  4  store byte lanes; bit n = bits 8n+7:8n.
- resp_valid_o  output  1  response available.
- resp_ready_i  input  1  initiator takes the response.
- read_data_o  output  32  load data.
- error_o  output  1  request was misaligned or out of range; qualified by resp_valid_o.

Function
REQ-005 The FSM SHALL have states IDLE, WAIT and RESP.
REQ-006 req_ready_o SHALL be 1 only in IDLE; resp_valid_o SHALL be 1 only in RESP.
REQ-007 In IDLE, req_valid_i=1 SHALL accept the request and register address, write flag, write data and byte enables; request inputs at all other times SHALL be ignored.
REQ-008 On accept with WAIT_STATES=0, the next state SHALL be RESP; otherwise it SHALL be WAIT with the wait counter loaded to WAIT_STATES.
REQ-009 In WAIT the counter SHALL decrement by 1 per cycle, and the FSM SHALL move to RESP on the edge where the counter equals 1.
REQ-010 resp_valid_o SHALL first assert exactly WAIT_STATES+1 cycles after the accept edge.
REQ-011 Word offset SHALL be (address_i - BASE_ADDRESS) >> 2, computed modulo 2^32.
REQ-012 error SHALL be set when address_i[1:0] != 0 or when (address_i - BASE_ADDRESS) >= 4*MEMORY_DEPTH, including wrap-around below BASE_ADDRESS.
REQ-013 The storage access SHALL occur on the edge entering RESP.
REQ-014 A store without error SHALL update only the lanes with byte_en set; byte_en=0000 SHALL leave memory unchanged.
REQ-015 A load without error SHALL capture the full word into read_data_o; byte_en SHALL be ignored for loads.
REQ-016 A store response SHALL drive read_data_o = 0.
REQ-017 On error, memory SHALL be unmodified, read_data_o SHALL be 0 and error_o SHALL be 1.
REQ-018 In RESP, read_data_o and error_o SHALL hold stable until resp_ready_i=1.
REQ-019 The RESP handshake SHALL return the FSM to IDLE, with req_ready_o=1 the following cycle, so there are no same-cycle back-to-back accepts.
REQ-020 A load following a store to the same word SHALL return the stored data.
REQ-021 read_data_o and error_o SHALL be registered outputs with no combinational path from any input.

Reset
REQ-022 When reset=1 at an edge, state SHALL go to IDLE, the counter to 0, and read_data_o and error_o to 0, regardless of current state.
REQ-023 While in reset, req_ready_o SHALL be 1 (IDLE) and resp_valid_o SHALL be 0.
REQ-024 Reset asserted in WAIT or RESP SHALL abandon the transaction with no response; a store SHALL have no memory effect if reset occurs before the RESP-entry edge.
REQ-025 Storage contents SHALL NOT be cleared by reset.

Verification
REQ-026 Default parameters: store 0xDEADBEEF to 0x1001_0004 with byte_en=1111, then load 0x1001_0004 -> resp_valid_o 3 cycles after each accept; load returns 0xDEADBEEF with error_o=0.
REQ-027 Word 0 = 0x11223344; store 0xAABBCCDD to 0x1001_0000 with byte_en=0101 -> a subsequent load returns 0x11BB33DD.
REQ-028 Load from 0x1001_0002 and from 0x1001_0400 (DEPTH 256), and store to 0x1000_FFFC -> each gives error_o=1, read_data_o=0, and memory unchanged.
REQ-029 Hold resp_ready_i=0 for 5 cycles during RESP -> resp_valid_o, read_data_o and error_o are stable; req_valid_i=1 during this time is not accepted and req_ready_o=0.
REQ-030 Assert reset during the WAIT of a store of 0x12345678 to 0x1001_0008 -> next cycle IDLE with outputs 0; a later load of 0x1001_0008 returns the prior contents.
REQ-031 With WAIT_STATES=0, a load with req_valid_i and resp_ready_i held high -> resp_valid_o the cycle after accept, and accepts occur every 2 cycles.
